ofdm_cp_insert: RTL and testbench

- Transmit-side back end for the OFDM modem.
- Captures one IFFT output symbol (modulation results, mdm=1) of N samples, written in any order by y_index, into a ping-pong buffer.
- Streams the completed symbol out in time order, prefixed by a cyclic prefix of its last CP_LEN samples, over a valid/ready interface to the DAC/framing path.
- Demodulation results (mdm=0) are ignored.

---
 rtl/ofdm_cp_insert_if.sv | 27 ++
 rtl/ofdm_cp_insert.sv | 149 ++++++++++++++
 tb/tb_ofdm_cp_insert.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_cp_insert_if.sv
// Transmit sample stream from the CP inserter to the DAC/framing path.
// A beat moves on any clock where tx_valid and tx_ready are both high.
interface ofdm_cp_insert_if #(
   parameter int W = 32
);
   logic [W-1:0] tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic         tx_sop;
   logic         tx_eop;

   modport master (
      output tx_data,
      output tx_valid,
      output tx_sop,
      output tx_eop,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      input  tx_sop,
      input  tx_eop,
      output tx_ready
   );
endinterface

// File: rtl/ofdm_cp_insert.sv
// Ping-pong capture of IFFT output symbols; each completed symbol is streamed in time order
// with a cyclic prefix made from its last CP_LEN samples.
module ofdm_cp_insert #(
   parameter int N      = 256,
   parameter int CP_LEN = 32,
   parameter int W      = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [W-1:0]         y_in,
   input  logic [$clog2(N)-1:0] y_index,
   input  logic                 mdm,
   input  logic                 in_valid,
   ofdm_cp_insert_if.master     tx,
   output logic                 overflow,
   output logic [15:0]          sym_count
);
   localparam int AW    = $clog2(N);
   localparam int BEATS = N + CP_LEN;
   localparam int KW    = $clog2(BEATS);
   localparam logic [KW-1:0] LAST_K   = KW'(BEATS - 1);
   localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

   typedef enum logic {IDLE, STREAM} state_t;

   logic [W-1:0] mem [0:2*N-1];
   logic [W-1:0] mem_q;

   state_t        state, state_next;
   logic [1:0]    bank_full;
   logic          wr_bank, rd_bank;
   logic          f_bank, f_bank_next;
   logic [KW-1:0] f_k, f_k_next;
   logic [AW-1:0] f_addr;
   logic          fetch, advance, accept_eop, wr_en, wr_close, wr_drop;

   logic          a_valid, a_sop, a_eop;
   logic [W-1:0]  tx_data_q;
   logic          tx_valid_q, tx_sop_q, tx_eop_q;

   assign tx.tx_data  = tx_data_q;
   assign tx.tx_valid = tx_valid_q;
   assign tx.tx_sop   = tx_sop_q;
   assign tx.tx_eop   = tx_eop_q;

   assign advance    = !tx_valid_q || tx.tx_ready;
   assign accept_eop = tx_valid_q && tx.tx_ready && tx_eop_q;
   assign wr_en      = in_valid && mdm && !bank_full[wr_bank];
   assign wr_drop    = in_valid && mdm && bank_full[wr_bank];
   assign wr_close   = wr_en && (y_index == LAST_IDX);
   assign f_addr     = AW'(f_k + KW'(N - CP_LEN));

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[{wr_bank, y_index}] <= y_in;
   end

   always_ff @(posedge clk) begin
      if (fetch)
         mem_q <= mem[{f_bank, f_addr}];
   end

   // Bank ownership: the writer closes a bank on index N-1, the reader frees it on the accepted eop beat.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bank_full <= 2'b00;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         overflow  <= 1'b0;
         sym_count <= 16'd0;
      end else begin
         if (accept_eop) begin
            bank_full[rd_bank] <= 1'b0;
            rd_bank            <= ~rd_bank;
            sym_count          <= sym_count + 16'd1;
         end
         if (wr_close) begin
            bank_full[wr_bank] <= 1'b1;
            wr_bank            <= ~wr_bank;
         end
         if (wr_drop)
            overflow <= 1'b1;
      end
   end

   // Fetcher runs one beat ahead of the output register so the synchronous RAM read never bubbles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         f_k    <= '0;
         f_bank <= 1'b0;
      end else begin
         state  <= state_next;
         f_k    <= f_k_next;
         f_bank <= f_bank_next;
      end
   end

   always_comb begin
      state_next  = state;
      f_k_next    = f_k;
      f_bank_next = f_bank;
      fetch       = 1'b0;
      case (state)
         IDLE: begin
            if (advance && bank_full[f_bank]) begin
               fetch      = 1'b1;
               f_k_next   = KW'(1);
               state_next = STREAM;
            end
         end
         STREAM: begin
            if (advance) begin
               fetch = 1'b1;
               if (f_k == LAST_K) begin
                  f_k_next    = '0;
                  f_bank_next = ~f_bank;
                  state_next  = IDLE;
               end else begin
                  f_k_next = f_k + KW'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Two-stage pipe (RAM output, then tx register); both stages hold together under backpressure.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_valid    <= 1'b0;
         a_sop      <= 1'b0;
         a_eop      <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         tx_sop_q   <= 1'b0;
         tx_eop_q   <= 1'b0;
      end else if (advance) begin
         a_valid    <= fetch;
         a_sop      <= fetch && (f_k == '0);
         a_eop      <= fetch && (f_k == LAST_K);
         tx_valid_q <= a_valid;
         tx_sop_q   <= a_sop;
         tx_eop_q   <= a_eop;
         if (a_valid)
            tx_data_q <= mem_q;
      end
   end
endmodule

// File: tb/tb_ofdm_cp_insert.sv
// Directed bench for ofdm_cp_insert: symbol capture orders, CP streaming, backpressure,
// back-to-back symbols, overflow and asynchronous reset.
module tb_ofdm_cp_insert;
   localparam int N     = 256;
   localparam int CP    = 32;
   localparam int W     = 32;
   localparam int BEATS = N + CP;

   logic        clk = 1'b0;
   logic        reset;
   logic [W-1:0] y_in;
   logic [7:0]  y_index;
   logic        mdm, in_valid;
   logic        overflow;
   logic [15:0] sym_count;

   ofdm_cp_insert_if #(.W(W)) tx_if();

   ofdm_cp_insert #(.N(N), .CP_LEN(CP), .W(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .y_in     (y_in),
      .y_index  (y_index),
      .mdm      (mdm),
      .in_valid (in_valid),
      .tx       (tx_if),
      .overflow (overflow),
      .sym_count(sym_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] cap_data [0:2047];
   logic         cap_sop  [0:2047];
   logic         cap_eop  [0:2047];
   int           cap_n, cap_gaps, cap_stall_err;
   bit           cap_timeout;
   int           bad_data, bad_flags, first_bad;
   logic [W-1:0] first_act, first_exp;

   task automatic do_reset();
      reset = 1'b0; in_valid = 1'b0; mdm = 1'b0; y_in = '0; y_index = '0;
      tx_if.tx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic write_symbol(input logic [W-1:0] base, input bit bitrev, input bit junk);
      for (int i = 0; i < N; i++) begin
         logic [7:0] fwd, idx;
         fwd = 8'(i);
         for (int b = 0; b < 8; b++) idx[b] = bitrev ? fwd[7-b] : fwd[b];
         if (junk) begin
            y_in = 32'hDEAD_0000 | 32'(i); y_index = idx; mdm = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
         end
         y_in = base + 32'(idx); y_index = idx; mdm = 1'b1; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; mdm = 1'b0;
   endtask

   // Records accepted beats; counts bubbles after the first beat and any change while stalled.
   task automatic capture(input int nbeats, input bit toggle, input int budget);
      bit started = 0, prev_stall = 0;
      logic [W-1:0] prev_d = '0;
      logic prev_s = 1'b0, prev_e = 1'b0;
      int cyc = 0;
      cap_n = 0; cap_gaps = 0; cap_stall_err = 0;
      while (cap_n < nbeats && cyc < budget) begin
         if (prev_stall && (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== prev_d ||
                            tx_if.tx_sop !== prev_s || tx_if.tx_eop !== prev_e))
            cap_stall_err++;
         tx_if.tx_ready = toggle ? ~cyc[0] : 1'b1;
         if (tx_if.tx_valid === 1'b1) started = 1;
         else if (started) cap_gaps++;
         if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready) begin
            cap_data[cap_n] = tx_if.tx_data;
            cap_sop[cap_n]  = tx_if.tx_sop;
            cap_eop[cap_n]  = tx_if.tx_eop;
            cap_n++;
         end
         prev_stall = (tx_if.tx_valid === 1'b1) && !tx_if.tx_ready;
         prev_d = tx_if.tx_data; prev_s = tx_if.tx_sop; prev_e = tx_if.tx_eop;
         @(posedge clk); #1;
         cyc++;
      end
      cap_timeout = (cap_n < nbeats);
   endtask

   // Expected beat k of a symbol is sample (k + N - CP) mod N of that symbol.
   function automatic void scan_stream(input logic [W-1:0] base0, input logic [W-1:0] base1);
      bad_data = 0; bad_flags = 0; first_bad = -1; first_act = '0; first_exp = '0;
      for (int k = 0; k < cap_n; k++) begin
         int b;
         logic [W-1:0] exp_d;
         b = k % BEATS;
         exp_d = ((k < BEATS) ? base0 : base1) + 32'((b + N - CP) % N);
         if (cap_data[k] !== exp_d) begin
            if (first_bad < 0) begin first_bad = k; first_act = cap_data[k]; first_exp = exp_d; end
            bad_data++;
         end
         if (cap_sop[k] !== (b == 0) || cap_eop[k] !== (b == BEATS - 1)) bad_flags++;
      end
   endfunction

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; mdm = 1'b0; y_in = '0; y_index = '0; tx_if.tx_ready = 1'b1;
      #3;
      checks++; if (tx_if.tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", tx_if.tx_valid); end
      checks++; if (tx_if.tx_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", tx_if.tx_data); end
      checks++; if (tx_if.tx_sop !== 1'b0) begin errors++; $display("[TB] FAIL reset_sop: got %0b expected 0", tx_if.tx_sop); end
      checks++; if (tx_if.tx_eop !== 1'b0) begin errors++; $display("[TB] FAIL reset_eop: got %0b expected 0", tx_if.tx_eop); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow); end
      checks++; if (sym_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_symcount: got %0d expected 0", sym_count); end
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_in_order();
      do_reset();
      write_symbol(32'h0, 1'b0, 1'b0);
      checks++; if (tx_if.tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_edge0: valid got %0b expected 0", tx_if.tx_valid); end
      @(posedge clk); #1;
      checks++; if (tx_if.tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_edge1: valid got %0b expected 0", tx_if.tx_valid); end
      @(posedge clk); #1;
      checks++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_sop !== 1'b1 || tx_if.tx_data !== 32'd224) begin
         errors++; $display("[TB] FAIL latency_edge2: valid %0b sop %0b data %0h expected 1 1 e0", tx_if.tx_valid, tx_if.tx_sop, tx_if.tx_data); end
      capture(BEATS, 1'b0, 1000);
      scan_stream(32'h0, 32'h0);
      checks++; if (cap_timeout) begin errors++; $display("[TB] FAIL inorder_timeout: got %0d beats expected %0d", cap_n, BEATS); end
      checks++; if (bad_data !== 0) begin errors++; $display("[TB] FAIL inorder_data: %0d bad, beat %0d got %0h expected %0h", bad_data, first_bad, first_act, first_exp); end
      checks++; if (bad_flags !== 0) begin errors++; $display("[TB] FAIL inorder_flags: got %0d bad sop/eop beats expected 0", bad_flags); end
      checks++; if (cap_gaps !== 0) begin errors++; $display("[TB] FAIL inorder_gaps: got %0d expected 0", cap_gaps); end
      checks++; if (sym_count !== 16'd1) begin errors++; $display("[TB] FAIL inorder_symcount: got %0d expected 1", sym_count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL inorder_overflow: got %0b expected 0", overflow); end
      checks++; if (tx_if.tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL inorder_idle: valid got %0b expected 0", tx_if.tx_valid); end
   endtask

   task automatic test_bitrev();
      do_reset();
      write_symbol(32'h0, 1'b1, 1'b0);
      capture(BEATS, 1'b0, 1000);
      scan_stream(32'h0, 32'h0);
      checks++; if (cap_timeout) begin errors++; $display("[TB] FAIL bitrev_timeout: got %0d beats expected %0d", cap_n, BEATS); end
      checks++; if (bad_data !== 0) begin errors++; $display("[TB] FAIL bitrev_data: %0d bad, beat %0d got %0h expected %0h", bad_data, first_bad, first_act, first_exp); end
      checks++; if (bad_flags !== 0) begin errors++; $display("[TB] FAIL bitrev_flags: got %0d bad sop/eop beats expected 0", bad_flags); end
      checks++; if (sym_count !== 16'd1) begin errors++; $display("[TB] FAIL bitrev_symcount: got %0d expected 1", sym_count); end
   endtask

   task automatic test_backpressure();
      do_reset();
      write_symbol(32'h0, 1'b0, 1'b0);
      capture(BEATS, 1'b1, 2000);
      scan_stream(32'h0, 32'h0);
      checks++; if (cap_timeout) begin errors++; $display("[TB] FAIL bp_timeout: got %0d beats expected %0d", cap_n, BEATS); end
      checks++; if (cap_stall_err !== 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d changes while stalled expected 0", cap_stall_err); end
      checks++; if (bad_data !== 0) begin errors++; $display("[TB] FAIL bp_data: %0d bad, beat %0d got %0h expected %0h", bad_data, first_bad, first_act, first_exp); end
      checks++; if (bad_flags !== 0) begin errors++; $display("[TB] FAIL bp_flags: got %0d bad sop/eop beats expected 0", bad_flags); end
      checks++; if (sym_count !== 16'd1) begin errors++; $display("[TB] FAIL bp_symcount: got %0d expected 1", sym_count); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      fork
         begin
            write_symbol(32'h0, 1'b0, 1'b0);
            write_symbol(32'h100, 1'b0, 1'b0);
         end
         capture(2 * BEATS, 1'b0, 3000);
      join
      scan_stream(32'h0, 32'h100);
      checks++; if (cap_timeout) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d beats expected %0d", cap_n, 2 * BEATS); end
      checks++; if (cap_gaps !== 0) begin errors++; $display("[TB] FAIL b2b_gaps: got %0d expected 0", cap_gaps); end
      checks++; if (bad_data !== 0) begin errors++; $display("[TB] FAIL b2b_data: %0d bad, beat %0d got %0h expected %0h", bad_data, first_bad, first_act, first_exp); end
      checks++; if (bad_flags !== 0) begin errors++; $display("[TB] FAIL b2b_flags: got %0d bad sop/eop beats expected 0", bad_flags); end
      checks++; if (cap_data[BEATS] !== 32'h1E0 || cap_sop[BEATS] !== 1'b1) begin
         errors++; $display("[TB] FAIL b2b_second_sop: data %0h sop %0b expected 1e0 1", cap_data[BEATS], cap_sop[BEATS]); end
      checks++; if (sym_count !== 16'd2) begin errors++; $display("[TB] FAIL b2b_symcount: got %0d expected 2", sym_count); end
   endtask

   task automatic test_overflow();
      int stray = 0;
      do_reset();
      tx_if.tx_ready = 1'b0;
      write_symbol(32'h0, 1'b0, 1'b0);
      write_symbol(32'h100, 1'b0, 1'b0);
      write_symbol(32'h200, 1'b0, 1'b0);
      checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %0b expected 1", overflow); end
      checks++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 32'd224) begin
         errors++; $display("[TB] FAIL ovf_held_beat: valid %0b data %0h expected 1 e0", tx_if.tx_valid, tx_if.tx_data); end
      capture(2 * BEATS, 1'b0, 3000);
      scan_stream(32'h0, 32'h100);
      checks++; if (cap_timeout) begin errors++; $display("[TB] FAIL ovf_timeout: got %0d beats expected %0d", cap_n, 2 * BEATS); end
      checks++; if (bad_data !== 0) begin errors++; $display("[TB] FAIL ovf_data: %0d bad, beat %0d got %0h expected %0h", bad_data, first_bad, first_act, first_exp); end
      checks++; if (cap_gaps !== 0) begin errors++; $display("[TB] FAIL ovf_gaps: got %0d expected 0", cap_gaps); end
      checks++; if (sym_count !== 16'd2) begin errors++; $display("[TB] FAIL ovf_symcount: got %0d expected 2", sym_count); end
      repeat (300) begin
         if (tx_if.tx_valid === 1'b1) stray++;
         @(posedge clk); #1;
      end
      checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL ovf_third_symbol: got %0d extra valid cycles expected 0", stray); end
   endtask

   // Runs straight on from the overflow scenario so the sticky flag is still set going into reset.
   task automatic test_mdm_reset();
      checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL mdm_overflow_sticky: got %0b expected 1", overflow); end
      write_symbol(32'h4000, 1'b0, 1'b1);
      capture(100, 1'b0, 1000);
      scan_stream(32'h4000, 32'h4000);
      checks++; if (cap_timeout) begin errors++; $display("[TB] FAIL mdm_timeout: got %0d beats expected 100", cap_n); end
      checks++; if (bad_data !== 0) begin errors++; $display("[TB] FAIL mdm_data: %0d bad, beat %0d got %0h expected %0h", bad_data, first_bad, first_act, first_exp); end
      checks++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 32'h4044) begin
         errors++; $display("[TB] FAIL mdm_beat100: valid %0b data %0h expected 1 4044", tx_if.tx_valid, tx_if.tx_data); end
      checks++; if (sym_count !== 16'd2) begin errors++; $display("[TB] FAIL mdm_symcount_pre: got %0d expected 2", sym_count); end
      reset = 1'b0;
      #2;
      checks++; if (tx_if.tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_valid: got %0b expected 0", tx_if.tx_valid); end
      checks++; if (tx_if.tx_data !== 32'h0) begin errors++; $display("[TB] FAIL async_data: got %0h expected 0", tx_if.tx_data); end
      checks++; if (tx_if.tx_sop !== 1'b0 || tx_if.tx_eop !== 1'b0) begin
         errors++; $display("[TB] FAIL async_flags: sop %0b eop %0b expected 0 0", tx_if.tx_sop, tx_if.tx_eop); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL async_overflow: got %0b expected 0", overflow); end
      checks++; if (sym_count !== 16'd0) begin errors++; $display("[TB] FAIL async_symcount: got %0d expected 0", sym_count); end
      #2 reset = 1'b1;
      @(posedge clk); #1;
      write_symbol(32'h5000, 1'b0, 1'b0);
      capture(BEATS, 1'b0, 1000);
      scan_stream(32'h5000, 32'h5000);
      checks++; if (cap_timeout) begin errors++; $display("[TB] FAIL post_reset_timeout: got %0d beats expected %0d", cap_n, BEATS); end
      checks++; if (bad_data !== 0) begin errors++; $display("[TB] FAIL post_reset_data: %0d bad, beat %0d got %0h expected %0h", bad_data, first_bad, first_act, first_exp); end
      checks++; if (bad_flags !== 0) begin errors++; $display("[TB] FAIL post_reset_flags: got %0d bad sop/eop beats expected 0", bad_flags); end
      checks++; if (sym_count !== 16'd1) begin errors++; $display("[TB] FAIL post_reset_symcount: got %0d expected 1", sym_count); end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_bitrev();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      test_mdm_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
